// File: rtl/rv32im_dmem_pkg.sv
// rv32im_dmem_pkg
// Shared constants, responder state encoding and the address range helper
// used by the rv32im_dmem data-memory responder and its RAM.
package rv32im_dmem_pkg;

    localparam int API_DATA_WIDTH  = 32;
    localparam int DMEM_MASK_WIDTH = 4;
    localparam int DMEM_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'd0,
        DMEM_ST_WAIT = 2'd1,
        DMEM_ST_RESP = 2'd2
    } dmem_state_e;

    // 33-bit arithmetic so a window ending at 4 GiB does not wrap.
    function automatic logic dmem_in_range(
        input logic [API_DATA_WIDTH-1:0] addr,
        input logic [API_DATA_WIDTH-1:0] base,
        input logic [API_DATA_WIDTH:0]   span
    );
        logic [API_DATA_WIDTH:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/rv32im_dmem_ram.sv
// rv32im_dmem_ram
// Single-port DEPTH x 32 array with per-byte write enables and a
// registered (synchronous) read. Contents are never reset.
// Ports:
//   clk_i    clock, rising edge
//   we_i     byte-lane write enables, bit n writes wdata_i byte n
//   idx_i    word index for both read and write
//   wdata_i  write data
//   rdata_o  word at idx_i, registered on the rising edge
module rv32im_dmem_ram
    import rv32im_dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                       clk_i,
    input  logic [DMEM_MASK_WIDTH-1:0] we_i,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic [API_DATA_WIDTH-1:0]  wdata_i,
    output logic [API_DATA_WIDTH-1:0]  rdata_o
);

    logic [API_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [API_DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DMEM_MASK_WIDTH; b++) begin
            if (we_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32im_dmem.sv
// rv32im_dmem
// Data-memory responder on the far side of the LSU memory port. Accepts one
// word-aligned request at a time, waits LATENCY cycles, then returns a
// one-cycle response strobe with the raw read word (or zero for writes and
// out-of-range accesses).
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   enable_i     request valid (held by requester until accepted)
//   addr_mem_i   byte address, bits [1:0] ignored
//   wr_mask_i    byte write enables, 0 means read
//   val_memwr_i  lane-shifted write data
//   ready_o      request accepted on this edge if enable_i is high
//   rvalid_o     one-cycle response strobe
//   val_memrd_o  read word during the response cycle, else 0
//   err_o        response is for an out-of-range access
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down wait states (cnt_q reaches 0 before RESP)
// RESP  | response cycle; pending write commits on the edge leaving it
module rv32im_dmem
    import rv32im_dmem_pkg::*;
#(
    parameter int unsigned          DEPTH     = 1024,
    parameter logic [31:0]          BASE_ADDR = 32'h0000_0000,
    parameter int unsigned          LATENCY   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic [API_DATA_WIDTH-1:0]  addr_mem_i,
    input  logic [DMEM_MASK_WIDTH-1:0] wr_mask_i,
    input  logic [API_DATA_WIDTH-1:0]  val_memwr_i,
    output logic                       ready_o,
    output logic                       rvalid_o,
    output logic [API_DATA_WIDTH-1:0]  val_memrd_o,
    output logic                       err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [API_DATA_WIDTH:0] SPAN = (API_DATA_WIDTH+1)'(DEPTH) * 33'd4;
    localparam logic [DMEM_CNT_WIDTH-1:0] CNT_LOAD =
        (LATENCY >= 2) ? DMEM_CNT_WIDTH'(LATENCY - 2) : '0;

    dmem_state_e                state_q, state_d;
    logic [DMEM_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q;
    logic [DMEM_MASK_WIDTH-1:0] mask_q;
    logic [API_DATA_WIDTH-1:0]  wdata_q;
    logic                       in_range_q;

    logic                       accept;
    logic                       req_in_range;
    logic [API_DATA_WIDTH-1:0]  req_off;
    logic [IDX_W-1:0]           req_idx;
    logic [IDX_W-1:0]           ram_idx;
    logic [DMEM_MASK_WIDTH-1:0] ram_we;
    logic [API_DATA_WIDTH-1:0]  ram_rdata;
    logic                       unused_off_bits;

    assign accept       = enable_i && (state_q == DMEM_ST_IDLE);
    assign req_in_range = dmem_in_range(addr_mem_i, BASE_ADDR, SPAN);
    assign req_off      = addr_mem_i - BASE_ADDR;
    assign req_idx      = req_off[IDX_W+1:2];
    assign unused_off_bits = ^{req_off[1:0], req_off[API_DATA_WIDTH-1:IDX_W+2]};

    // With LATENCY==1 the accept edge is also the RESP entry edge, so the RAM
    // must be addressed straight from the request while idle.
    assign ram_idx = (state_q == DMEM_ST_IDLE) ? req_idx : idx_q;
    assign ram_we  = (state_q == DMEM_ST_RESP && in_range_q) ? mask_q : '0;

    rv32im_dmem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DMEM_ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q      <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            in_range_q <= 1'b0;
        end else if (accept) begin
            idx_q      <= req_idx;
            mask_q     <= wr_mask_i;
            wdata_q    <= val_memwr_i;
            in_range_q <= req_in_range;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMEM_ST_IDLE: begin
                if (enable_i) begin
                    if (LATENCY == 1) begin
                        state_d = DMEM_ST_RESP;
                    end else begin
                        state_d = DMEM_ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DMEM_ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DMEM_ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMEM_ST_RESP: state_d = DMEM_ST_IDLE;
            default:      state_d = DMEM_ST_IDLE;
        endcase
    end

    assign ready_o     = (state_q == DMEM_ST_IDLE);
    assign rvalid_o    = (state_q == DMEM_ST_RESP);
    assign err_o       = (state_q == DMEM_ST_RESP) && !in_range_q;
    assign val_memrd_o = (state_q == DMEM_ST_RESP && in_range_q && mask_q == '0)
                         ? ram_rdata : '0;

endmodule
